// File: rtl/stu_context_copy_manager.sv
// Copies x1..x(NUM_REGS-1) from a master core's register file into a speculative
// core, then loads the speculative start PC. Abortable at any point.
package stu_pkg;
  typedef logic [1:0]  core_id_t;
  typedef logic [31:0] addr_t;
endpackage

module stu_context_copy_manager #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        copy_start_in,
  input  stu_pkg::core_id_t           src_core_id_in,
  input  stu_pkg::core_id_t           dst_core_id_in,
  input  stu_pkg::addr_t              spec_pc_in,
  input  logic                        abort_in,
  output logic                        rf_rd_req_out,
  output stu_pkg::core_id_t           rf_rd_core_out,
  output logic [$clog2(NUM_REGS)-1:0] rf_rd_addr_out,
  input  logic [XLEN-1:0]             rf_rd_data_in,
  output logic                        rf_wr_en_out,
  output stu_pkg::core_id_t           rf_wr_core_out,
  output logic [$clog2(NUM_REGS)-1:0] rf_wr_addr_out,
  output logic [XLEN-1:0]             rf_wr_data_out,
  input  logic                        rf_wr_ready_in,
  output logic                        pc_wr_en_out,
  output stu_pkg::addr_t              pc_wr_data_out,
  output logic                        copy_done_out,
  output logic                        busy_out
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, PC_WRITE, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [XLEN-1:0]   data_q;
  stu_pkg::core_id_t src_q, dst_q;
  stu_pkg::addr_t    pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      data_q <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      pc_q   <= '0;
    end else if (state != IDLE && abort_in) begin
      // abort wins over write accept and DONE in the same cycle
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (copy_start_in && src_core_id_in != dst_core_id_in) begin
            src_q <= src_core_id_in;
            dst_q <= dst_core_id_in;
            pc_q  <= spec_pc_in;
            idx   <= IW'(1);
            state <= READ;
          end
        READ:    state <= CAPTURE;
        CAPTURE: begin
          data_q <= rf_rd_data_in;
          state  <= WRITE;
        end
        WRITE:
          if (rf_wr_ready_in) begin
            if (idx == LAST_IDX) state <= PC_WRITE;
            else begin
              idx   <= idx + IW'(1);
              state <= READ;
            end
          end
        PC_WRITE: state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state; every field is gated by its enable.
  always_comb begin
    rf_rd_req_out  = (state == READ);
    rf_rd_core_out = rf_rd_req_out ? src_q : '0;
    rf_rd_addr_out = rf_rd_req_out ? idx : '0;
    rf_wr_en_out   = (state == WRITE);
    rf_wr_core_out = rf_wr_en_out ? dst_q : '0;
    rf_wr_addr_out = rf_wr_en_out ? idx : '0;
    rf_wr_data_out = rf_wr_en_out ? data_q : '0;
    pc_wr_en_out   = (state == PC_WRITE);
    pc_wr_data_out = pc_wr_en_out ? pc_q : '0;
    copy_done_out  = (state == DONE);
    busy_out       = (state != IDLE);
  end
endmodule

// File: tb/tb_stu_context_copy_manager.sv
// Directed bench: nominal copy, backpressure, aborts, start collisions, mid-copy reset.
module tb_stu_context_copy_manager;
  logic        clk = 0, rst = 1;
  logic        copy_start = 0, abort = 0, ready = 1;
  logic [1:0]  src_id = 0, dst_id = 0;
  logic [31:0] spec_pc = 0;
  logic        rd_req, wr_en, pc_wr, done, busy;
  logic [1:0]  rd_core, wr_core;
  logic [4:0]  rd_addr, wr_addr;
  logic [31:0] rd_data = 0, wr_data, pc_data;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  // register file read model: data one cycle after the request
  always @(posedge clk) rd_data <= rd_req ? 32'hA000_0000 + 32'(rd_addr) : 32'h0;

  stu_context_copy_manager #(.NUM_REGS(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .copy_start_in(copy_start), .src_core_id_in(src_id),
    .dst_core_id_in(dst_id), .spec_pc_in(spec_pc), .abort_in(abort),
    .rf_rd_req_out(rd_req), .rf_rd_core_out(rd_core), .rf_rd_addr_out(rd_addr),
    .rf_rd_data_in(rd_data), .rf_wr_en_out(wr_en), .rf_wr_core_out(wr_core),
    .rf_wr_addr_out(wr_addr), .rf_wr_data_out(wr_data), .rf_wr_ready_in(ready),
    .pc_wr_en_out(pc_wr), .pc_wr_data_out(pc_data), .copy_done_out(done), .busy_out(busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {rd_req, rd_core, rd_addr, wr_en, wr_core, wr_addr, pc_wr, done, busy} |
           {32'h0, wr_data | pc_data};
  endfunction

  // Start a copy at a negedge and watch every following cycle (rel = cycles after the start).
  task automatic do_copy(input logic [1:0] src, input logic [1:0] dst, input logic [31:0] pc,
                         input int stall_reg, input int stall_len, input int abort_rel,
                         input int busy_start_rel, input int exp_writes, input int exp_pc_rel,
                         input int exp_done_rel, input string tag);
    int writes = 0, pc_rel = -1, done_rel = -1, stalls = 0, viol = 0, nxt_rd = 1, nxt_wr = 1;
    bit prev_rd = 0;
    logic [31:0] pcd = 0;
    @(negedge clk);
    copy_start = 1; src_id = src; dst_id = dst; spec_pc = pc; abort = (abort_rel == 0);
    for (int rel = 1; rel <= 200; rel++) begin
      @(negedge clk);
      copy_start = (rel == busy_start_rel);
      dst_id     = (rel == busy_start_rel) ? ~dst : dst;
      abort      = (rel == abort_rel);
      if (wr_en && int'(wr_addr) == stall_reg && stalls < stall_len) begin
        ready = 0;
        stalls++;
        if (wr_core != dst || wr_data != 32'hA000_0000 + 32'(stall_reg)) viol++;
      end else ready = 1;
      if (rd_req) begin
        if (int'(rd_addr) != nxt_rd || rd_core != src || prev_rd) viol++;
        nxt_rd++;
      end else if (rd_addr != 0 || rd_core != 0) viol++;
      prev_rd = rd_req;
      if (wr_en && ready) begin
        if (int'(wr_addr) != nxt_wr || wr_core != dst || wr_data != 32'hA000_0000 + 32'(nxt_wr))
          viol++;
        nxt_wr++;
        writes++;
      end
      if (!wr_en && (wr_addr != 0 || wr_core != 0 || wr_data != 0)) viol++;
      if (pc_wr) begin pc_rel = rel; pcd = pc_data; end
      else if (pc_data != 0) viol++;
      if (done) done_rel = rel;
      if (abort_rel > 0 && rel == abort_rel + 1 && busy) viol++;
      if (done_rel >= 0) break;
      if (abort_rel > 0 && rel >= abort_rel + 8) break;
    end
    copy_start = 0; abort = 0; ready = 1; dst_id = dst;
    chk({tag, "_writes"}, writes, exp_writes);
    chk({tag, "_pc_cycle"}, pc_rel, exp_pc_rel);
    chk({tag, "_done_cycle"}, done_rel, exp_done_rel);
    chk({tag, "_protocol"}, viol, 0);
    if (exp_pc_rel >= 0) chk({tag, "_pc_data"}, pcd, pc);
    if (abort_rel > 0) chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #1 chk("reset_outs", all_outs(), 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // nominal, with a start while busy at rel 40 (ignored)
    do_copy(0, 2, 32'h1000, -1, 0, -1, 40, 31, 94, 95, "nominal");
    // back-to-back start in the IDLE cycle right after DONE, x7 stalled 5 cycles
    do_copy(1, 3, 32'h2468, 7, 5, -1, -1, 31, 99, 100, "backpressure");
    // abort during CAPTURE of x10
    do_copy(0, 2, 32'h3000, -1, 0, 29, -1, 9, -1, -1, "abort_x10");
    // abort coincident with x31 write accept
    do_copy(2, 1, 32'h4000, -1, 0, 93, -1, 31, -1, -1, "abort_x31");
    // abort asserted together with start while IDLE is ignored
    do_copy(3, 0, 32'h5000, -1, 0, 0, -1, 31, 94, 95, "abort_idle");

    // src == dst is ignored
    @(negedge clk); copy_start = 1; src_id = 1; dst_id = 1;
    @(negedge clk); copy_start = 0;
    chk("same_core_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("same_core_rd", rd_req, 0);

    // reset during WRITE of x20 (rel 60)
    @(negedge clk); copy_start = 1; src_id = 1; dst_id = 3; spec_pc = 32'h6000;
    @(negedge clk); copy_start = 0;
    repeat (59) @(negedge clk);
    chk("pre_rst_wr_en", wr_en, 1);
    chk("pre_rst_wr_addr", wr_addr, 20);
    #2 rst = 1;
    #1 chk("rst_async_outs", all_outs(), 0);
    @(negedge clk); rst = 0;
    do_copy(1, 3, 32'h7000, -1, 0, -1, -1, 31, 94, 95, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
